// File: rtl/t2mi_ts_mux.sv
// t2mi_ts_mux: round-robin multiplexer of N_CH T2-MI byte streams into one
// 188-byte transport stream. Each packet carries its channel PID, a
// per-channel continuity counter, and a pointer field or a zero-length
// adaptation field chosen from the distance to the next T2-MI packet start.
// Empty slots are filled with null packets when NULL_INSERT=1.
module t2mi_ts_mux #(
    parameter int N_CH        = 2,
    parameter int LEVEL_W     = 12,
    parameter bit NULL_INSERT = 1'b1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    SLOT_EN,
    input  logic [8*N_CH-1:0]       CH_DATA,
    input  logic [LEVEL_W*N_CH-1:0] CH_LEVEL,
    input  logic [8*N_CH-1:0]       CH_SOP_DIST,
    input  logic [13*N_CH-1:0]      CH_PID,
    output logic [N_CH-1:0]         CH_RD_REQ,
    output logic [7:0]              DATA_OUT,
    output logic                    ENA_OUT,
    output logic                    PSYNC_OUT,
    output logic [2:0]              CH_SEL
);

    typedef enum logic [1:0] {
        ARB = 2'd0,
        HDR = 2'd1,
        PAY = 2'd2
    } state_t;

    localparam logic [LEVEL_W-1:0] READY_LEVEL = LEVEL_W'(184);
    localparam logic [2:0]         NULL_SEL    = 3'd7;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  rr_q, rr_d;
    logic [2:0]  grant_q, grant_d;
    logic        null_q, null_d;
    logic [12:0] pid_q, pid_d;
    logic [7:0]  dist_q, dist_d;
    logic [3:0]  cc_q [8];
    logic [3:0]  cc_d [8];
    logic [7:0]  data_q, data_d;
    logic        ena_q, ena_d;
    logic        psync_q, psync_d;
    logic [2:0]  sel_q, sel_d;

    logic [7:0]  data_arr_s [8];
    logic [7:0]  dist_arr_s [8];
    logic [12:0] pid_arr_s  [8];
    logic [7:0]  ready_s;
    logic        found_s;
    logic [2:0]  win_s;
    logic [3:0]  idx_s;
    logic        pusi_s;
    logic [1:0]  afc_s;
    logic        extra_s;
    logic [3:0]  cc_cur_s;
    logic        pay_read_s;

    // Unpack the per-channel buses into 8-entry arrays; unused lanes read as zero
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
        if (gi < N_CH) begin : g_used
            assign data_arr_s[gi] = CH_DATA[8*gi +: 8];
            assign dist_arr_s[gi] = CH_SOP_DIST[8*gi +: 8];
            assign pid_arr_s[gi]  = CH_PID[13*gi +: 13];
            assign ready_s[gi]    = (CH_LEVEL[LEVEL_W*gi +: LEVEL_W] >= READY_LEVEL);
        end else begin : g_unused
            assign data_arr_s[gi] = 8'd0;
            assign dist_arr_s[gi] = 8'd0;
            assign pid_arr_s[gi]  = 13'd0;
            assign ready_s[gi]    = 1'b0;
        end
    end

    // Round-robin search: first ready channel at or after the pointer, with wrap
    always_comb begin
        found_s = 1'b0;
        win_s   = 3'd0;
        idx_s   = 4'd0;
        for (int k = 0; k < N_CH; k++) begin
            idx_s = {1'b0, rr_q} + 4'(k);
            if (idx_s >= 4'(N_CH)) begin
                idx_s = idx_s - 4'(N_CH);
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && ready_s[idx_s[2:0]]) begin
                found_s = 1'b1;
                win_s   = idx_s[2:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Header fields derived from the latched distance; null packets use fixed fields
    always_comb begin
        pusi_s   = !null_q && (dist_q <= 8'd182);
        extra_s  = !null_q && (dist_q <= 8'd183);
        afc_s    = (!null_q && (dist_q == 8'd183)) ? 2'b11 : 2'b01;
        cc_cur_s = null_q ? 4'd0 : cc_q[grant_q];
    end

    // Packet sequencer: arbitration, header bytes, payload bytes, CC update
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rr_d       = rr_q;
        grant_d    = grant_q;
        null_d     = null_q;
        pid_d      = pid_q;
        dist_d     = dist_q;
        sel_d      = sel_q;
        data_d     = data_q;
        ena_d      = 1'b0;
        psync_d    = 1'b0;
        pay_read_s = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cc_d[i] = cc_q[i];
        end
        if (SLOT_EN) begin
            case (state_q)
                ARB: begin
                    if (found_s) begin
                        grant_d = win_s;
                        null_d  = 1'b0;
                        pid_d   = pid_arr_s[win_s];
                        dist_d  = dist_arr_s[win_s];
                        sel_d   = win_s;
                        rr_d    = (win_s == 3'(N_CH - 1)) ? 3'd0 : (win_s + 3'd1);
                        data_d  = 8'h47;
                        ena_d   = 1'b1;
                        psync_d = 1'b1;
                        cnt_d   = 8'd1;
                        state_d = HDR;
                    end else if (NULL_INSERT) begin
                        null_d  = 1'b1;
                        pid_d   = 13'h1FFF;
                        dist_d  = 8'hFF;
                        sel_d   = NULL_SEL;
                        data_d  = 8'h47;
                        ena_d   = 1'b1;
                        psync_d = 1'b1;
                        cnt_d   = 8'd1;
                        state_d = HDR;
                    end else begin
                        state_d = ARB;
                    end
                end
                HDR: begin
                    ena_d = 1'b1;
                    cnt_d = cnt_q + 8'd1;
                    case (cnt_q)
                        8'd1:    data_d = {1'b0, pusi_s, 1'b0, pid_q[12:8]};
                        8'd2:    data_d = pid_q[7:0];
                        default: begin
                            data_d  = {2'b00, afc_s, cc_cur_s};
                            state_d = PAY;
                        end
                    endcase
                end
                PAY: begin
                    ena_d = 1'b1;
                    cnt_d = cnt_q + 8'd1;
                    if (null_q) begin
                        data_d = 8'hFF;
                    end else if ((cnt_q == 8'd4) && extra_s) begin
                        // pointer field, or adaptation_field_length 0 when d == 183
                        data_d = pusi_s ? dist_q : 8'h00;
                    end else begin
                        pay_read_s = 1'b1;
                        data_d     = data_arr_s[grant_q];
                    end
                    if (cnt_q == 8'd187) begin
                        cnt_d   = 8'd0;
                        state_d = ARB;
                        if (!null_q) begin
                            cc_d[grant_q] = cc_q[grant_q] + 4'd1;
                        end else begin
                            cc_d[grant_q] = cc_q[grant_q];
                        end
                    end else begin
                        state_d = PAY;
                    end
                end
                default: begin
                    cnt_d   = 8'd0;
                    state_d = ARB;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Pop strobe is combinational so the head byte is consumed in the deciding cycle
    always_comb begin
        CH_RD_REQ = {N_CH{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            CH_RD_REQ[i] = !RST && pay_read_s && (grant_q == 3'(i));
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ARB;
            cnt_q   <= 8'd0;
            rr_q    <= 3'd0;
            grant_q <= 3'd0;
            null_q  <= 1'b0;
            pid_q   <= 13'd0;
            dist_q  <= 8'd0;
            data_q  <= 8'd0;
            ena_q   <= 1'b0;
            psync_q <= 1'b0;
            sel_q   <= NULL_SEL;
            for (int i = 0; i < 8; i++) begin
                cc_q[i] <= 4'd0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            null_q  <= null_d;
            pid_q   <= pid_d;
            dist_q  <= dist_d;
            data_q  <= data_d;
            ena_q   <= ena_d;
            psync_q <= psync_d;
            sel_q   <= sel_d;
            for (int i = 0; i < 8; i++) begin
                cc_q[i] <= cc_d[i];
            end
        end
    end

    assign DATA_OUT  = data_q;
    assign ENA_OUT   = ena_q;
    assign PSYNC_OUT = psync_q;
    assign CH_SEL    = sel_q;

endmodule

// File: tb/tb_t2mi_ts_mux.sv
// Bench for t2mi_ts_mux: each packet is predicted from the TS rules (arbitration
// order, header layout, CC per channel, FIFO byte stream) and compared byte by byte.
module tb_t2mi_ts_mux;
    localparam int N = 2;

    logic            clk, rst, slot_en;
    logic [8*N-1:0]  ch_data, ch_sop;
    logic [12*N-1:0] ch_level, zero_level;
    logic [13*N-1:0] ch_pid;
    logic [N-1:0]    ch_rd_req, b_rd_req;
    logic [7:0]      data_out, b_data_out;
    logic            ena_out, psync_out, b_ena_out, b_psync_out;
    logic [2:0]      ch_sel, b_ch_sel;

    t2mi_ts_mux #(.N_CH(N), .LEVEL_W(12), .NULL_INSERT(1'b1)) dut (
        .CLK(clk), .RST(rst), .SLOT_EN(slot_en), .CH_DATA(ch_data), .CH_LEVEL(ch_level),
        .CH_SOP_DIST(ch_sop), .CH_PID(ch_pid), .CH_RD_REQ(ch_rd_req), .DATA_OUT(data_out),
        .ENA_OUT(ena_out), .PSYNC_OUT(psync_out), .CH_SEL(ch_sel));

    // Second instance without null insertion, never given a ready channel
    t2mi_ts_mux #(.N_CH(N), .LEVEL_W(12), .NULL_INSERT(1'b0)) dut_idle (
        .CLK(clk), .RST(rst), .SLOT_EN(slot_en), .CH_DATA(ch_data), .CH_LEVEL(zero_level),
        .CH_SOP_DIST(ch_sop), .CH_PID(ch_pid), .CH_RD_REQ(b_rd_req), .DATA_OUT(b_data_out),
        .ENA_OUT(b_ena_out), .PSYNC_OUT(b_psync_out), .CH_SEL(b_ch_sel));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int lvl [N];
    int sop [N];
    int pid [N];
    int rd_cnt [N];
    int pkt_reads [N];
    int m_cc [N];
    int m_rd_idx [N];
    int exp_reads [N];
    int m_rr;
    int exp_sel;
    logic [7:0] exp_d [$];
    logic [7:0] got_d [$];
    bit         got_p [$];
    logic [2:0] got_s [$];
    int checks, errors, ena_bad, side_bad;

    // Byte stream content of channel c at position idx
    function automatic logic [7:0] pat(input int c, input int idx);
        return 8'(c * 97 + idx * 31 + (idx / 8) * 7 + 11);
    endfunction

    task automatic drive_data();
        for (int c = 0; c < N; c++) ch_data[8*c +: 8] = pat(c, rd_cnt[c]);
    endtask

    task automatic apply();
        for (int c = 0; c < N; c++) begin
            ch_level[12*c +: 12] = 12'(lvl[c]);
            ch_sop[8*c +: 8]     = 8'(sop[c]);
            ch_pid[13*c +: 13]   = 13'(pid[c]);
        end
        drive_data();
    endtask

    // One clock: pops sampled mid-cycle, outputs sampled just after the edge
    task automatic tick();
        logic [N-1:0] req;
        logic slot_prev, rst_prev;
        slot_prev = slot_en;
        rst_prev  = rst;
        @(negedge clk);
        req = ch_rd_req;
        if ($countones(req) > 1) ena_bad++;
        if (b_rd_req !== '0) side_bad++;
        @(posedge clk);
        #1;
        for (int c = 0; c < N; c++) begin
            if (req[c]) begin
                rd_cnt[c]++;
                pkt_reads[c]++;
            end
        end
        if (ena_out !== (slot_prev && !rst_prev)) ena_bad++;
        if (b_ena_out !== 1'b0) side_bad++;
        if (ena_out === 1'b1) begin
            got_d.push_back(data_out);
            got_p.push_back(psync_out);
            got_s.push_back(ch_sel);
        end
        drive_data();
    endtask

    // Reference: which channel wins and the full 188-byte packet it produces
    task automatic predict();
        int g, d, n, c;
        g = -1;
        exp_d.delete();
        for (int k = 0; k < N; k++) begin
            c = (m_rr + k) % N;
            if (g < 0 && lvl[c] >= 184) g = c;
        end
        for (int k = 0; k < N; k++) exp_reads[k] = 0;
        if (g < 0) begin
            exp_sel = 7;
            exp_d.push_back(8'h47); exp_d.push_back(8'h1F);
            exp_d.push_back(8'hFF); exp_d.push_back(8'h10);
            repeat (184) exp_d.push_back(8'hFF);
        end else begin
            m_rr = (g + 1) % N;
            d = sop[g];
            exp_sel = g;
            exp_d.push_back(8'h47);
            exp_d.push_back(8'(((d <= 182) ? 64 : 0) + (pid[g] / 256)));
            exp_d.push_back(8'(pid[g] % 256));
            exp_d.push_back(8'(((d == 183) ? 48 : 16) + m_cc[g]));
            n = 184;
            if (d <= 182) begin exp_d.push_back(8'(d)); n = 183; end
            else if (d == 183) begin exp_d.push_back(8'h00); n = 183; end
            for (int j = 0; j < n; j++) exp_d.push_back(pat(g, m_rd_idx[g] + j));
            m_rd_idx[g] += n;
            exp_reads[g] = n;
            m_cc[g] = (m_cc[g] + 1) % 16;
        end
    endtask

    task automatic run_packet(input string name, input bit toggle, input bit scramble);
        int n, first, last, bad;
        predict();
        got_d.delete(); got_p.delete(); got_s.delete();
        for (int c = 0; c < N; c++) pkt_reads[c] = 0;
        ena_bad = 0;
        n = 0; first = -1;
        slot_en = 1'b1;
        while (got_d.size() < 188 && n < 1000) begin
            tick();
            n++;
            if (first < 0 && got_d.size() > 0) first = n;
            if (scramble && got_d.size() == 20) begin
                for (int c = 0; c < N; c++) sop[c] = $urandom_range(0, 255);
                apply();
            end
            slot_en = toggle ? !slot_en : 1'b1;
        end
        last = n;
        slot_en = 1'b0;
        checks++;
        if (got_d.size() != 188) begin
            errors++;
            $display("FAIL %s length got %0d exp 188", name, got_d.size());
        end
        checks++; bad = -1;
        for (int i = 0; i < 4 && i < got_d.size(); i++) if (bad < 0 && got_d[i] !== exp_d[i]) bad = i;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s header byte %0d got %02h exp %02h", name, bad, got_d[bad], exp_d[bad]);
        end
        checks++; bad = -1;
        for (int i = 4; i < got_d.size(); i++) if (bad < 0 && got_d[i] !== exp_d[i]) bad = i;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s payload byte %0d got %02h exp %02h", name, bad, got_d[bad], exp_d[bad]);
        end
        checks++; bad = -1;
        for (int i = 0; i < got_p.size(); i++) if (bad < 0 && got_p[i] !== (i == 0)) bad = i;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s psync at byte %0d got %0d exp %0d", name, bad, got_p[bad], (bad == 0));
        end
        checks++; bad = -1;
        for (int i = 0; i < got_s.size(); i++) if (bad < 0 && got_s[i] !== 3'(exp_sel)) bad = i;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s ch_sel at byte %0d got %0d exp %0d", name, bad, got_s[bad], exp_sel);
        end
        for (int c = 0; c < N; c++) begin
            checks++;
            if (pkt_reads[c] != exp_reads[c]) begin
                errors++;
                $display("FAIL %s reads ch%0d got %0d exp %0d", name, c, pkt_reads[c], exp_reads[c]);
            end
        end
        checks++;
        if (ena_bad != 0) begin
            errors++;
            $display("FAIL %s ena/pop timing got %0d bad cycles exp 0", name, ena_bad);
        end
        checks++;
        if ((last - first) != (toggle ? 374 : 187)) begin
            errors++;
            $display("FAIL %s span got %0d exp %0d", name, last - first, toggle ? 374 : 187);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        slot_en = 1'b0;
        tick();
        tick();
        checks += 5;
        if (data_out !== 8'h00) begin errors++; $display("FAIL reset data got %02h exp 00", data_out); end
        if (ena_out !== 1'b0) begin errors++; $display("FAIL reset ena got %0d exp 0", ena_out); end
        if (psync_out !== 1'b0) begin errors++; $display("FAIL reset psync got %0d exp 0", psync_out); end
        if (ch_sel !== 3'd7) begin errors++; $display("FAIL reset ch_sel got %0d exp 7", ch_sel); end
        if (ch_rd_req !== '0) begin errors++; $display("FAIL reset rd_req got %0h exp 0", ch_rd_req); end
        rst = 1'b0;
        m_rr = 0;
        for (int c = 0; c < N; c++) begin m_cc[c] = 0; m_rd_idx[c] = rd_cnt[c]; end
    endtask

    task automatic test_round_robin();
        lvl = '{400, 400}; sop = '{255, 255}; pid = '{32'h1000, 32'h1001};
        apply();
        run_packet("rr_p0", 1'b0, 1'b0);
        run_packet("rr_p1", 1'b0, 1'b0);
        run_packet("rr_p2", 1'b0, 1'b0);
    endtask

    task automatic test_layouts();
        lvl = '{400, 0}; sop = '{5, 255}; pid = '{32'h1000, 32'h1001};
        apply();
        run_packet("pointer_d5", 1'b0, 1'b0);
        sop[0] = 183; apply();
        run_packet("afield_d183", 1'b0, 1'b0);
        sop[0] = 182; apply();
        run_packet("pointer_d182", 1'b0, 1'b1);
        sop[0] = 184; apply();
        run_packet("plain_d184", 1'b0, 1'b0);
    endtask

    task automatic test_null_and_level();
        lvl = '{183, 100}; sop = '{5, 5}; apply();
        run_packet("null_pkt", 1'b0, 1'b0);
        lvl = '{183, 184}; pid[1] = $urandom_range(0, 8190); apply();
        run_packet("level_184", 1'b0, 1'b0);
    endtask

    task automatic test_slot_toggle();
        lvl = '{400, 0}; sop = '{$urandom_range(0, 255), 255}; pid[0] = $urandom_range(0, 8191);
        apply();
        run_packet("slot_toggle", 1'b1, 1'b0);
    endtask

    task automatic test_cc_wrap_reset();
        int n;
        lvl = '{0, 400}; sop = '{255, 255}; pid[1] = $urandom_range(0, 8191);
        apply();
        for (int p = 0; p < 17; p++) run_packet($sformatf("cc_pkt%0d", p), 1'b0, 1'b0);
        got_d.delete(); got_p.delete(); got_s.delete();
        for (int c = 0; c < N; c++) pkt_reads[c] = 0;
        slot_en = 1'b1; n = 0;
        while (got_d.size() < 50 && n < 200) begin tick(); n++; end
        rst = 1'b1;
        tick();
        checks += 4;
        if (pkt_reads[1] != 46) begin errors++; $display("FAIL trunc reads got %0d exp 46", pkt_reads[1]); end
        if (ena_out !== 1'b0) begin errors++; $display("FAIL trunc ena got %0d exp 0", ena_out); end
        if (ch_sel !== 3'd7) begin errors++; $display("FAIL trunc ch_sel got %0d exp 7", ch_sel); end
        if (data_out !== 8'h00) begin errors++; $display("FAIL trunc data got %02h exp 00", data_out); end
        rst = 1'b0; slot_en = 1'b0;
        m_rr = 0;
        for (int c = 0; c < N; c++) begin m_cc[c] = 0; m_rd_idx[c] = rd_cnt[c]; end
        lvl = '{400, 400}; apply();
        run_packet("post_rst_ch0", 1'b0, 1'b0);
        run_packet("post_rst_ch1", 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int r;
        for (int p = 0; p < 8; p++) begin
            for (int c = 0; c < N; c++) begin
                lvl[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 183) : $urandom_range(184, 4095);
                r = $urandom_range(0, 5);
                sop[c] = (r == 0) ? 183 : (r == 1) ? 182 : (r == 2) ? 184 :
                         (r == 3) ? $urandom_range(0, 181) : $urandom_range(185, 255);
                pid[c] = $urandom_range(0, 8191);
            end
            apply();
            run_packet($sformatf("rand%0d", p), 1'($urandom_range(0, 1)), 1'b1);
        end
    endtask

    initial begin
        checks = 0; errors = 0; ena_bad = 0; side_bad = 0;
        rst = 1'b1; slot_en = 1'b0; zero_level = '0;
        for (int c = 0; c < N; c++) begin
            rd_cnt[c] = 0; lvl[c] = 0; sop[c] = 255; pid[c] = 0;
        end
        apply();
        test_reset();
        test_round_robin();
        test_layouts();
        test_null_and_level();
        test_slot_toggle();
        test_cc_wrap_reset();
        test_random();
        checks++;
        if (side_bad != 0) begin
            errors++;
            $display("FAIL idle_no_null activity got %0d cycles exp 0", side_bad);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
